rram_op_sequencer: RTL and testbench

Cycle-accurate phase sequencer for one RRAM crossbar operation (READ, SET, RESET, MAC). It accepts one command over a valid/ready handshake and drives the WL/BL/SL driver select buses. It times precharge, pulse and sense phases, captures the CSA or ADC result, and returns it with a one-cycle response strobe. It sits between the Wishbone-facing RRAM controller register logic and the analog array periphery.

---
 rtl/rram_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rram_op_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rram_op_sequencer.sv
// rram_op_sequencer: phase sequencer driving WL/BL/SL selects and enables for one RRAM crossbar op
module rram_op_sequencer #(
    parameter int PRE_CYCLES   = 4,
    parameter int PULSE_CYCLES = 8,
    parameter int SENSE_CYCLES = 3,
    parameter int ADC_CYCLES   = 6,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_wl,
    input  logic [15:0] cmd_data,
    output logic        ENABLE_WL,
    output logic        ENABLE_BL,
    output logic        ENABLE_SL,
    output logic        ENABLE_CSA,
    output logic        PRE,
    output logic        SAEN_CSA,
    output logic [1:0]  CLK_EN_ADC,
    output logic [15:0] IN0_WL,
    output logic [15:0] IN1_WL,
    output logic [15:0] IN0_BL,
    output logic [15:0] IN1_BL,
    output logic [15:0] IN0_SL,
    output logic [15:0] IN1_SL,
    input  logic [15:0] CSA,
    input  logic [15:0] ADC_OUT0,
    input  logic [15:0] ADC_OUT1,
    input  logic [15:0] ADC_OUT2,
    output logic        rsp_valid,
    output logic [47:0] rsp_data,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SETUP, PRECHARGE, PULSE, SENSE, RECOVER} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b10;
    localparam logic [1:0] OP_MAC   = 2'b11;

    state_t     state;
    logic [1:0] op;
    logic [7:0] cnt;
    logic       sensed;

    assign sensed = (op == OP_READ) || (op == OP_MAC);

    // Phase FSM; every output is registered so drivers and enables switch on clean edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op         <= OP_READ;
            cnt        <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            ENABLE_WL  <= 1'b0;
            ENABLE_BL  <= 1'b0;
            ENABLE_SL  <= 1'b0;
            ENABLE_CSA <= 1'b0;
            PRE        <= 1'b0;
            SAEN_CSA   <= 1'b0;
            CLK_EN_ADC <= 2'b00;
            IN0_WL     <= '0;
            IN1_WL     <= '0;
            IN0_BL     <= '0;
            IN1_BL     <= '0;
            IN0_SL     <= '0;
            IN1_SL     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    state     <= SETUP;
                    op        <= cmd_op;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    IN1_WL    <= cmd_wl;
                    IN0_WL    <= ~cmd_wl;
                    IN1_BL    <= (cmd_op == OP_SET) ? cmd_data : (cmd_op == OP_RESET) ? 16'h0000 : 16'hFFFF;
                    IN0_BL    <= (cmd_op == OP_SET) ? ~cmd_data : (cmd_op == OP_RESET) ? 16'hFFFF : 16'h0000;
                    IN1_SL    <= (cmd_op == OP_RESET) ? cmd_data : 16'h0000;
                    IN0_SL    <= (cmd_op == OP_RESET) ? ~cmd_data : 16'hFFFF;
                end
                SETUP: if (sensed) begin
                    state <= PRECHARGE;
                    PRE   <= 1'b1;
                    cnt   <= 8'(PRE_CYCLES - 1);
                end else begin
                    state     <= PULSE;
                    ENABLE_WL <= 1'b1;
                    ENABLE_BL <= 1'b1;
                    ENABLE_SL <= 1'b1;
                    cnt       <= 8'(PULSE_CYCLES - 1);
                end
                PRECHARGE: if (cnt == 8'd0) begin
                    state      <= PULSE;
                    PRE        <= 1'b0;
                    ENABLE_WL  <= 1'b1;
                    ENABLE_BL  <= 1'b1;
                    ENABLE_SL  <= 1'b1;
                    ENABLE_CSA <= (op == OP_READ);
                    cnt        <= 8'(PULSE_CYCLES - 1);
                end else begin
                    cnt <= cnt - 8'd1;
                end
                PULSE: if (cnt == 8'd0) begin
                    if (sensed) begin
                        state      <= SENSE;
                        SAEN_CSA   <= (op == OP_READ);
                        CLK_EN_ADC <= (op == OP_MAC) ? 2'b11 : 2'b00;
                        cnt        <= (op == OP_READ) ? 8'(SENSE_CYCLES - 1) : 8'(ADC_CYCLES - 1);
                    end else begin
                        state     <= RECOVER;
                        ENABLE_WL <= 1'b0;
                        ENABLE_BL <= 1'b0;
                        ENABLE_SL <= 1'b0;
                        rsp_data  <= '0;
                        rsp_valid <= (GAP_CYCLES == 1);
                        cnt       <= 8'(GAP_CYCLES - 1);
                    end
                end else begin
                    cnt <= cnt - 8'd1;
                end
                SENSE: if (cnt == 8'd0) begin
                    state      <= RECOVER;
                    ENABLE_WL  <= 1'b0;
                    ENABLE_BL  <= 1'b0;
                    ENABLE_SL  <= 1'b0;
                    ENABLE_CSA <= 1'b0;
                    SAEN_CSA   <= 1'b0;
                    CLK_EN_ADC <= 2'b00;
                    rsp_data   <= (op == OP_READ) ? {32'h0, CSA} : {ADC_OUT2, ADC_OUT1, ADC_OUT0};
                    rsp_valid  <= (GAP_CYCLES == 1);
                    cnt        <= 8'(GAP_CYCLES - 1);
                end else begin
                    cnt <= cnt - 8'd1;
                end
                RECOVER: if (cnt == 8'd0) begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    IN0_WL    <= '0;
                    IN1_WL    <= '0;
                    IN0_BL    <= '0;
                    IN1_BL    <= '0;
                    IN0_SL    <= '0;
                    IN1_SL    <= '0;
                end else begin
                    cnt       <= cnt - 8'd1;
                    rsp_valid <= (cnt == 8'd1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rram_op_sequencer.sv
// tb_rram_op_sequencer: directed + random scoreboard bench for rram_op_sequencer
module tb_rram_op_sequencer;
  localparam int P  = 4;
  localparam int PU = 8;
  localparam int S  = 3;
  localparam int A  = 6;
  localparam int G  = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_wl, cmd_data;
  logic        ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, PRE, SAEN_CSA;
  logic [1:0]  CLK_EN_ADC;
  logic [15:0] IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL;
  logic [15:0] CSA, ADC_OUT0, ADC_OUT1, ADC_OUT2;
  logic        rsp_valid;
  logic [47:0] rsp_data;
  logic        busy;
  rram_op_sequencer #(.PRE_CYCLES(P), .PULSE_CYCLES(PU), .SENSE_CYCLES(S), .ADC_CYCLES(A), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wl(cmd_wl), .cmd_data(cmd_data), .ENABLE_WL(ENABLE_WL), .ENABLE_BL(ENABLE_BL),
    .ENABLE_SL(ENABLE_SL), .ENABLE_CSA(ENABLE_CSA), .PRE(PRE), .SAEN_CSA(SAEN_CSA),
    .CLK_EN_ADC(CLK_EN_ADC), .IN0_WL(IN0_WL), .IN1_WL(IN1_WL), .IN0_BL(IN0_BL),
    .IN1_BL(IN1_BL), .IN0_SL(IN0_SL), .IN1_SL(IN1_SL), .CSA(CSA), .ADC_OUT0(ADC_OUT0),
    .ADC_OUT1(ADC_OUT1), .ADC_OUT2(ADC_OUT2), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          due;
    logic [47:0] data;
  } ent_t;
  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc = 0;
  int   last_rsp = -1;
  int   acc_cyc = 0;
  logic [95:0]  in_now, in_prev;
  logic         any_en, prev_en;
  logic [180:0] all_out;
  assign in_now  = {IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL};
  assign any_en  = ENABLE_WL | ENABLE_BL | ENABLE_SL | ENABLE_CSA;
  assign all_out = {busy, rsp_valid, rsp_data, PRE, ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA,
                    SAEN_CSA, CLK_EN_ADC, in_now};
  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int lat(input logic [1:0] op);
    return (op == 2'b00) ? 1 + P + PU + S + G : (op == 2'b11) ? 1 + P + PU + A + G : 1 + PU + G;
  endfunction
  function automatic logic [95:0] exp_in(input logic [1:0] op, input logic [15:0] wl, input logic [15:0] d);
    if (op == 2'b01) return {~wl, wl, ~d, d, 16'hFFFF, 16'h0000};
    if (op == 2'b10) return {~wl, wl, 16'hFFFF, 16'h0000, ~d, d};
    return {~wl, wl, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
  endfunction
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      chk("inv_pre_en", PRE && any_en, 1'b0);
      chk("inv_saen_adc", SAEN_CSA && (|CLK_EN_ADC), 1'b0);
      if (any_en || prev_en) chk("inv_in_stable", in_now, in_prev);
      if (rsp_valid) begin
        last_rsp = ncyc;
        if (q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          ent_t e;
          e = q.pop_front();
          chk("rsp_cycle", ncyc, e.due);
          chk("rsp_data", rsp_data, e.data);
        end
      end
    end
    prev_en = any_en;
    in_prev = in_now;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [15:0] wl, input logic [15:0] d,
                       input logic [15:0] csa, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic hold);
    ent_t e;
    step();
    cmd_op = op; cmd_wl = wl; cmd_data = d;
    CSA = csa; ADC_OUT0 = a0; ADC_OUT1 = a1; ADC_OUT2 = a2;
    cmd_valid = 1'b1;
    for (int t = 0; t < 100 && !cmd_ready; t++) step();
    chk("accept_ready", cmd_ready, 1'b1);
    acc_cyc = ncyc;
    e.due  = ncyc + lat(op);
    e.data = (op == 2'b00) ? {32'h0, csa} : (op == 2'b11) ? {a2, a1, a0} : 48'h0;
    q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = hold;
  endtask
  task automatic check_phases(input logic [1:0] op, input logic [15:0] wl, input logic [15:0] d);
    int          n, s, pe, se;
    logic        sn;
    logic [10:0] ev;
    n  = lat(op);
    sn = (op == 2'b00) || (op == 2'b11);
    s  = sn ? 2 + P : 2;
    pe = s + PU - 1;
    se = (op == 2'b00) ? pe + S : (op == 2'b11) ? pe + A : pe;
    for (int k = 1; k <= n + 1; k++) begin
      step();
      ev = {k <= n, k > n, sn && k >= 2 && k < s, {3{k >= s && k <= se}},
            op == 2'b00 && k >= s && k <= se, op == 2'b00 && k > pe && k <= se,
            {2{op == 2'b11 && k > pe && k <= se}}, k == n};
      chk($sformatf("phase op%0d c%0d", op, k),
          {busy, cmd_ready, PRE, ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, SAEN_CSA, CLK_EN_ADC, rsp_valid}, ev);
      chk($sformatf("in op%0d c%0d", op, k), in_now, (k <= n) ? exp_in(op, wl, d) : 96'h0);
    end
  endtask
  task automatic wait_rsp();
    for (int t = 0; t < 200 && q.size() != 0; t++) step();
    chk("rsp_pending", q.size(), 0);
  endtask
  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wl = '0; cmd_data = '0;
    CSA = '0; ADC_OUT0 = '0; ADC_OUT1 = '0; ADC_OUT2 = '0;
    repeat (3) step();
    chk("rst_outs", all_out, 181'h0);
    chk("rst_ready", cmd_ready, 1'b1);
    rst = 1'b1;
    issue(2'b01, 16'h0001, 16'h00F0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    repeat (5) step();
    chk("mid_pulse_en", ENABLE_WL, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_outs", all_out, 181'h0);
    chk("abort_ready", cmd_ready, 1'b1);
    q.delete();
    step();
    rst = 1'b1;
    issue(2'b00, 16'h0004, 16'h1234, 16'hA5A5, 16'h0, 16'h0, 16'h0, 1'b0);
    check_phases(2'b00, 16'h0004, 16'h1234);
    wait_rsp();
    chk("read_data", rsp_data, 48'h0000_0000_A5A5);
    issue(2'b01, 16'h0001, 16'h00F0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0);
    check_phases(2'b01, 16'h0001, 16'h00F0);
    wait_rsp();
    issue(2'b11, 16'h000F, 16'h0, 16'h0, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    check_phases(2'b11, 16'h000F, 16'h0);
    wait_rsp();
    chk("mac_data", rsp_data, 48'h0003_0002_0001);
    chk("rsp_hold", rsp_data, 48'h0003_0002_0001);
    issue(2'b10, 16'h0100, 16'h0F0F, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    issue(2'b00, 16'h0200, 16'h0, 16'h5A5A, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("b2b_accept", acc_cyc, last_rsp + 1);
    for (int t = 0; t < 40; t++) begin
      step();
      if (rsp_valid) break;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom);
    end
    cmd_valid = 1'b0;
    wait_rsp();
    for (int i = 0; i < 500; i++) begin
      logic [1:0]  op;
      logic [15:0] wl;
      op = 2'($urandom);
      wl = (op == 2'b11) ? 16'($urandom) : 16'h1 << $urandom_range(0, 15);
      issue(op, wl, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      for (int t = 0; t < 40; t++) begin
        step();
        if (rsp_valid) break;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_wl = 16'($urandom);
        cmd_data = 16'($urandom);
      end
      cmd_valid = 1'b0;
      wait_rsp();
      repeat ($urandom_range(0, 2)) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
